// File: rtl/m_mic_mem_bridge_if.sv
// Bundle of the controller-side and memory-side signals of the micro
// controller memory bridge. The master modport is the bridge's own view
// (it masters the memory bus); the slave modport is the surrounding
// controller/memory environment.
interface m_mic_mem_bridge_if;
    // Controller side
    logic [1:0]  i_mic_req;
    logic [31:0] i_mic_addr;
    logic [31:0] i_mic_wdata;
    logic [2:0]  i_mic_ctrl;
    logic        o_stall;
    logic [31:0] o_data;
    // Memory / MMIO bus side
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    // Error reporting
    logic        o_err;
    logic        i_err_clr;

    modport master (
        input  i_mic_req, i_mic_addr, i_mic_wdata, i_mic_ctrl,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_err_clr,
        output o_stall, o_data, o_mem_valid, o_mem_addr, o_mem_we,
        output o_mem_wstrb, o_mem_wdata, o_err
    );

    modport slave (
        output i_mic_req, i_mic_addr, i_mic_wdata, i_mic_ctrl,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_err_clr,
        input  o_stall, o_data, o_mem_valid, o_mem_addr, o_mem_we,
        input  o_mem_wstrb, o_mem_wdata, o_err
    );
endinterface

// File: rtl/m_mic_mem_bridge.sv
// Bridge from the micro controller's non-local load/store requests
// (addr[31:28] != 0) onto a valid/ready request, rvalid response bus.
// The controller is stalled until the access completes; load data is
// lane-shifted and sign/zero extended, store data is lane-replicated with
// byte strobes. A response timeout forces completion and sets a sticky error.
module m_mic_mem_bridge #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic                 CLK,
    input  logic                 RST,
    m_mic_mem_bridge_if.master   bus
);

    // Controller access codes; code fetch (2) and idle (3) never hit.
    localparam logic [1:0] ACCESS_READ  = 2'd0;
    localparam logic [1:0] ACCESS_WRITE = 2'd1;

    // Last RSP cycle before a forced completion.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        hit;
    logic        is_write;
    logic        timeout_hit;
    logic        rsp_done;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [1:0]  lane;
    logic [2:0]  ctrl;
    logic [31:0] data;
    logic        err;
    logic [15:0] cnt;

    // Shift the addressed lane down and extend according to funct3.
    function automatic logic [31:0] load_fmt(input logic [31:0] rdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] w;
        w = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{24{w[7]}}, w[7:0]};
            3'b100:  load_fmt = {24'h0, w[7:0]};
            3'b001:  load_fmt = {{16{w[15]}}, w[15:0]};
            3'b101:  load_fmt = {16'h0, w[15:0]};
            default: load_fmt = w;
        endcase
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_strb(input logic [1:0] off,
                                              input logic [1:0] size);
        case (size)
            2'b00:   store_strb = 4'b0001 << off;
            2'b01:   store_strb = 4'b0011 << {off[1], 1'b0};
            default: store_strb = 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it may occupy.
    function automatic logic [31:0] store_data(input logic [31:0] d,
                                               input logic [1:0]  size);
        case (size)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    assign is_write    = (bus.i_mic_req == ACCESS_WRITE);
    assign hit         = ((bus.i_mic_req == ACCESS_READ) || is_write) &&
                         (bus.i_mic_addr[31:28] != 4'h0);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign rsp_done    = bus.i_mem_rvalid || timeout_hit;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the combinational stall and request valid.
    always_comb begin
        state_nxt       = state;
        bus.o_stall     = 1'b0;
        bus.o_mem_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.o_stall = hit;
                if (hit) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.o_stall     = 1'b1;
                bus.o_mem_valid = 1'b1;
                if (bus.i_mem_ready) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                bus.o_stall = 1'b1;
                if (rsp_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stall drops here so the controller leaves EX exactly once.
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the request on a hit; bus outputs then stay stable until the next hit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_addr  <= 32'h0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            lane      <= 2'b00;
            ctrl      <= 3'b000;
        end else if (state == ST_IDLE && hit) begin
            mem_addr  <= {bus.i_mic_addr[31:2], 2'b00};
            mem_we    <= is_write;
            mem_wstrb <= is_write ? store_strb(bus.i_mic_addr[1:0], bus.i_mic_ctrl[1:0]) : 4'h0;
            mem_wdata <= store_data(bus.i_mic_wdata, bus.i_mic_ctrl[1:0]);
            lane      <= bus.i_mic_addr[1:0];
            ctrl      <= bus.i_mic_ctrl;
        end
    end

    // Response timeout counter: cleared on entry to RSP, counts every RSP cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= 16'h0;
        end else if (state == ST_REQ && bus.i_mem_ready) begin
            cnt <= 16'h0;
        end else if (state == ST_RSP) begin
            cnt <= cnt + 16'h1;
        end
    end

    // Load result register; writes never touch it, a timed-out read returns ERR_DATA.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data <= 32'h0;
        end else if (state == ST_RSP && !mem_we) begin
            if (bus.i_mem_rvalid) begin
                data <= load_fmt(bus.i_mem_rdata, lane, ctrl);
            end else if (timeout_hit) begin
                data <= ERR_DATA;
            end
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as a clear wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (state == ST_RSP && !bus.i_mem_rvalid && timeout_hit) begin
            err <= 1'b1;
        end else if (bus.i_err_clr) begin
            err <= 1'b0;
        end
    end

    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_wstrb = mem_wstrb;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_data      = data;
    assign bus.o_err       = err;

endmodule

// File: tb/tb_m_mic_mem_bridge.sv
// Testbench for m_mic_mem_bridge: drives controller requests and a simple
// bus responder, scoreboards load results and checks handshake timing.
module tb_m_mic_mem_bridge;

    localparam logic [1:0] RD   = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] CODE = 2'd2;
    localparam logic [1:0] IDL  = 2'd3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_rd;
    logic [31:0] sb_q[$];

    m_mic_mem_bridge_if bus ();

    m_mic_mem_bridge #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hFFFF_FFFF)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access: hit, REQ (ready after ready_wait cycles), RSP
    // (rvalid on RSP cycle rsp_wait; negative = never), then DONE.
    task automatic run_access(input string tag, input logic [1:0] req,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input int ready_wait,
                              input int rsp_wait, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input int exp_stall,
                              input logic exp_err);
        int          stall_cnt;
        logic        bad;
        logic        done;
        logic [31:0] exp;
        step();
        bus.i_mic_req   = req;
        bus.i_mic_addr  = addr;
        bus.i_mic_wdata = wd;
        bus.i_mic_ctrl  = f3;
        if (req == RD) begin
            sb_q.push_back(exp_data);
            last_rd = exp_data;
        end else begin
            sb_q.push_back(last_rd);
        end
        stall_cnt = 0;
        bad       = 1'b0;
        @(negedge clk);
        check_val({tag, "_stall_hit"}, {31'h0, bus.o_stall}, 32'h1);
        check_val({tag, "_novalid_hit"}, {31'h0, bus.o_mem_valid}, 32'h0);
        stall_cnt++;
        step();
        for (int i = 0; i <= ready_wait; i++) begin
            bus.i_mem_ready = (i == ready_wait);
            @(negedge clk);
            if (bus.o_mem_valid !== 1'b1 || bus.o_stall !== 1'b1 ||
                bus.o_mem_addr !== {addr[31:2], 2'b00} || bus.o_mem_we !== (req == WR) ||
                bus.o_mem_wstrb !== exp_strb)
                bad = 1'b1;
            if (req == WR && bus.o_mem_wdata !== exp_wdata)
                bad = 1'b1;
            if (bus.o_stall === 1'b1)
                stall_cnt++;
            step();
        end
        bus.i_mem_ready = 1'b0;
        check_val({tag, "_req_stable"}, {31'h0, bad}, 32'h0);
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            bus.i_mem_rvalid = (i == rsp_wait);
            bus.i_mem_rdata  = rdata;
            @(negedge clk);
            if (bus.o_stall === 1'b0) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                step();
            end
        end
        bus.i_mem_rvalid = 1'b0;
        bus.i_mic_req    = IDL;
        check_val({tag, "_done_reached"}, {31'h0, done}, 32'h1);
        exp = sb_q.pop_front();
        check_val({tag, "_data"}, bus.o_data, exp);
        check_val({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        check_val({tag, "_err"}, {31'h0, bus.o_err}, {31'h0, exp_err});
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_rd = 32'h0;
        bus.i_mic_req    = IDL;
        bus.i_mic_addr   = 32'h0;
        bus.i_mic_wdata  = 32'h0;
        bus.i_mic_ctrl   = 3'b010;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
        bus.i_err_clr    = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_valid", {31'h0, bus.o_mem_valid}, 32'h0);
        check_val("rst_stall", {31'h0, bus.o_stall}, 32'h0);
        check_val("rst_data",  bus.o_data, 32'h0);
        check_val("rst_addr",  bus.o_mem_addr, 32'h0);
        check_val("rst_wstrb", {28'h0, bus.o_mem_wstrb}, 32'h0);
        check_val("rst_err",   {31'h0, bus.o_err}, 32'h0);

        // LW, ready at once, rvalid three cycles after the ready cycle
        run_access("lw", RD, 32'h8000_0004, 32'h0, 3'b010, 0, 2, 32'h1234_5678,
                   32'h1234_5678, 4'h0, 32'h0, 5, 1'b0);
        // Load formatting
        run_access("lb3", RD, 32'h8000_0003, 32'h0, 3'b000, 0, 0, 32'h80AA_BBCC,
                   32'hFFFF_FF80, 4'h0, 32'h0, 3, 1'b0);
        run_access("lbu3", RD, 32'h8000_0003, 32'h0, 3'b100, 1, 1, 32'h80AA_BBCC,
                   32'h0000_0080, 4'h0, 32'h0, 5, 1'b0);
        run_access("lhu2", RD, 32'h8000_0002, 32'h0, 3'b101, 0, 0, 32'h80AA_BBCC,
                   32'h0000_80AA, 4'h0, 32'h0, 3, 1'b0);
        run_access("lh2", RD, 32'h8000_0002, 32'h0, 3'b001, 0, 0, 32'h80AA_BBCC,
                   32'hFFFF_80AA, 4'h0, 32'h0, 3, 1'b0);
        run_access("lb1", RD, 32'h8000_0001, 32'h0, 3'b000, 0, 0, 32'h80AA_BBCC,
                   32'hFFFF_FFBB, 4'h0, 32'h0, 3, 1'b0);
        // Stores: o_data must keep the last load result
        run_access("sh2", WR, 32'h9000_0002, 32'h0000_BEEF, 3'b001, 0, 1, 32'h0,
                   32'h0, 4'b1100, 32'hBEEF_BEEF, 4, 1'b0);
        run_access("sb1", WR, 32'h9000_0001, 32'h1234_56A5, 3'b000, 0, 0, 32'h0,
                   32'h0, 4'b0010, 32'hA5A5_A5A5, 3, 1'b0);
        run_access("sw", WR, 32'h9000_0008, 32'hCAFE_F00D, 3'b010, 0, 0, 32'h0,
                   32'h0, 4'b1111, 32'hCAFE_F00D, 3, 1'b0);
        // Ready held low for 10 cycles (longer than TIMEOUT): no timeout in REQ
        run_access("slow_rdy", RD, 32'hA000_0010, 32'h0, 3'b010, 10, 1, 32'h0BAD_F00D,
                   32'h0BAD_F00D, 4'h0, 32'h0, 14, 1'b0);
        // Timeout after 8 RSP cycles
        run_access("tmo", RD, 32'hA000_0020, 32'h0, 3'b010, 0, -1, 32'h0,
                   32'hFFFF_FFFF, 4'h0, 32'h0, 10, 1'b1);

        // Late rvalid after the timeout is ignored
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h5555_5555;
        step();
        step();
        bus.i_mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("late_rvalid_data", bus.o_data, 32'hFFFF_FFFF);
        check_val("late_rvalid_valid", {31'h0, bus.o_mem_valid}, 32'h0);
        check_val("late_rvalid_err", {31'h0, bus.o_err}, 32'h1);
        step();
        bus.i_err_clr = 1'b1;
        step();
        bus.i_err_clr = 1'b0;
        @(negedge clk);
        check_val("err_clr", {31'h0, bus.o_err}, 32'h0);

        // Local address and code fetch are ignored
        step();
        bus.i_mic_req  = RD;
        bus.i_mic_addr = 32'h0000_0100;
        @(negedge clk);
        check_val("local_stall", {31'h0, bus.o_stall}, 32'h0);
        step();
        @(negedge clk);
        check_val("local_valid", {31'h0, bus.o_mem_valid}, 32'h0);
        step();
        bus.i_mic_req  = CODE;
        bus.i_mic_addr = 32'h8000_0000;
        @(negedge clk);
        check_val("code_stall", {31'h0, bus.o_stall}, 32'h0);
        step();
        @(negedge clk);
        check_val("code_valid", {31'h0, bus.o_mem_valid}, 32'h0);
        step();
        bus.i_mic_req = IDL;

        // Set the error again, then reset in the middle of a write response
        run_access("tmo2", RD, 32'hA000_0024, 32'h0, 3'b010, 0, -1, 32'h0,
                   32'hFFFF_FFFF, 4'h0, 32'h0, 10, 1'b1);
        bus.i_mic_req   = WR;
        bus.i_mic_addr  = 32'hB000_0003;
        bus.i_mic_wdata = 32'h0000_0077;
        bus.i_mic_ctrl  = 3'b000;
        step();
        bus.i_mem_ready = 1'b1;
        step();
        bus.i_mem_ready = 1'b0;
        step();
        @(negedge clk);
        check_val("pre_rst_stall", {31'h0, bus.o_stall}, 32'h1);
        check_val("pre_rst_wstrb", {28'h0, bus.o_mem_wstrb}, 32'h8);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_valid", {31'h0, bus.o_mem_valid}, 32'h0);
        check_val("mid_rst_we",    {31'h0, bus.o_mem_we}, 32'h0);
        check_val("mid_rst_wstrb", {28'h0, bus.o_mem_wstrb}, 32'h0);
        check_val("mid_rst_addr",  bus.o_mem_addr, 32'h0);
        check_val("mid_rst_wdata", bus.o_mem_wdata, 32'h0);
        check_val("mid_rst_data",  bus.o_data, 32'h0);
        check_val("mid_rst_err",   {31'h0, bus.o_err}, 32'h0);
        check_val("mid_rst_stall_hit", {31'h0, bus.o_stall}, 32'h1);
        bus.i_mic_req = IDL;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_stall", {31'h0, bus.o_stall}, 32'h0);

        // Bridge still works after the reset
        last_rd = 32'h0;
        run_access("post_rst_lw", RD, 32'h8000_0000, 32'h0, 3'b010, 0, 0, 32'h0102_0304,
                   32'h0102_0304, 4'h0, 32'h0, 3, 1'b0);
        check_val("sb_empty", sb_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
